// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit per clock through a single FA cell with a
// registered carry, wrapped in an IDLE/RUN/DONE start/busy/done handshake.

module FA (
    input  logic X,
    input  logic Y,
    input  logic Z,
    output logic C,
    output logic S
);
    assign S = X ^ Y ^ Z;
    assign C = (X & Y) | (X & Z) | (Y & Z);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_c_s;
    logic             fa_s_s;
    logic [WIDTH-1:0] part_d;
    logic             load_s;
    logic             last_s;

    FA u_fa (
        .X (opa_q[0]),
        .Y (opb_q[0]),
        .Z (carry_q),
        .C (fa_c_s),
        .S (fa_s_s)
    );

    // The newest sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
    generate
        if (WIDTH == 1) begin : g_part_w1
            assign part_d = fa_s_s;
        end else begin : g_part_wn
            assign part_d = {fa_s_s, part_q[WIDTH-1:1]};
        end
    endgenerate

    // Start is honoured in IDLE and in DONE (back-to-back), never during RUN.
    always_comb begin
        load_s = 1'b0;
        last_s = 1'b0;
        if (state_q != ST_RUN) begin
            load_s = start;
        end else begin
            load_s = 1'b0;
        end
        if (cnt_q == LAST_CNT) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Control FSM and serial datapath; reset abandons any addition in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (load_s) begin
            state_q <= ST_RUN;
            opa_q   <= a;
            opb_q   <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                ST_RUN: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    part_q  <= part_d;
                    carry_q <= fa_c_s;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_s) begin
                        sum_q   <= part_d;
                        cout_q  <= fa_c_s;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-table and random bench for serial_adder at WIDTH=8 and WIDTH=1.

module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [8];

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full 8-bit transaction with latency, busy window, result hold and done checks.
    task automatic run8(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input logic [8:0] exp);
        logic       win_ok;
        logic [8:0] prev;
        prev = {cout8, sum8};
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = ~ta; b8 = ~tb_; cin8 = ~tc;
        win_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!(busy8 === 1'b1 && done8 === 1'b0 && {cout8, sum8} === prev)) win_ok = 1'b0;
            if (i < 7) cyc();
        end
        check({name, "_busy_window"}, 64'(win_ok), 64'(1'b1));
        cyc();
        check({name, "_done"}, 64'(done8), 64'(1'b1));
        check({name, "_busy_at_done"}, 64'(busy8), 64'(1'b0));
        check({name, "_result"}, 64'({cout8, sum8}), 64'(exp));
        cyc();
        check({name, "_done_drop"}, 64'(done8), 64'(1'b0));
    endtask

    task automatic run1(input string name, input logic ta, input logic tb_, input logic tc,
                        input logic [1:0] exp);
        logic [1:0] prev;
        prev = {cout1, sum1};
        @(negedge clk);
        a1 = ta; b1 = tb_; cin1 = tc; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; a1 = ~ta; b1 = ~tb_; cin1 = ~tc;
        check({name, "_run"}, 64'({busy1, done1, cout1, sum1}), 64'({1'b1, 1'b0, prev}));
        cyc();
        check({name, "_done"}, 64'({busy1, done1}), 64'(2'b01));
        check({name, "_result"}, 64'({cout1, sum1}), 64'(exp));
        cyc();
        check({name, "_idle"}, 64'({busy1, done1}), 64'(2'b00));
    endtask

    initial begin
        int         dones;
        int         busies;
        logic       idle_ok;
        logic [8:0] got;
        logic [17:0] busy_v, busy_e, done_v, done_e;
        logic [8:0] r1, r2;
        logic [7:0] ra, rb;
        logic       rc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_state8", 64'({busy8, done8, cout8, sum8}), 64'(11'h000));
        check("reset_state1", 64'({busy1, done1, cout1, sum1}), 64'(4'h0));
        idle_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00) idle_ok = 1'b0;
        end
        check("idle_no_activity", 64'(idle_ok), 64'(1'b1));

        for (int i = 0; i < 8; i++) begin
            run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                 {vecs[i].cout, vecs[i].sum});
        end

        // Start re-asserted mid-run must be ignored.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        cyc(); cyc();
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        dones = 0; busies = 1; got = 9'h1AA;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (done8 === 1'b1) begin dones++; got = {cout8, sum8}; end
            if (busy8 === 1'b1) busies++;
        end
        check("midrun_done_count", 64'(dones), 64'(1));
        check("midrun_result", 64'(got), 64'(9'h096));
        check("midrun_busy_cycles", 64'(busies), 64'(5));

        // Reset in the middle of a run abandons it.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        cyc();
        check("midrst_outputs", 64'({busy8, done8, cout8, sum8}), 64'(11'h000));
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (done8 === 1'b1 || busy8 === 1'b1) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'(0));
        run8("after_rst", 8'h12, 8'h34, 1'b1, 9'h047);

        // Start held high through DONE: back-to-back additions.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        cyc();
        a8 = 8'hFF; b8 = 8'h01;
        busy_e = '1; busy_e[8] = 1'b0; busy_e[17] = 1'b0;
        done_e = '0; done_e[8] = 1'b1; done_e[17] = 1'b1;
        busy_v = '0; done_v = '0; r1 = '0; r2 = '0;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) cyc();
            busy_v[k] = busy8;
            done_v[k] = done8;
            if (k == 8) r1 = {cout8, sum8};
            if (k == 17) begin r2 = {cout8, sum8}; start8 = 1'b0; end
        end
        check("b2b_busy_pattern", 64'(busy_v), 64'(busy_e));
        check("b2b_done_pattern", 64'(done_v), 64'(done_e));
        check("b2b_result1", 64'(r1), 64'(9'h096));
        check("b2b_result2", 64'(r2), 64'(9'h100));
        cyc();
        check("b2b_idle", 64'({busy8, done8}), 64'(2'b00));

        run1("w1_111", 1'b1, 1'b1, 1'b1, 2'b11);
        run1("w1_100", 1'b1, 1'b0, 1'b0, 2'b01);
        run1("w1_110", 1'b1, 1'b1, 1'b0, 2'b10);
        run1("w1_000", 1'b0, 1'b0, 1'b0, 2'b00);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run8("rand8", ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc));
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run1("rand1", ra[0], rb[0], rc, 2'(ra[0]) + 2'(rb[0]) + 2'(rc));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: adds two WIDTH-bit operands one bit per clock.
- Reuses the team's existing 1-bit full-adder cell `FA` (inputs X, Y, Z; outputs C, S) as its only arithmetic element, plus a registered carry.
- Consumes the FA's C/S outputs every cycle and feeds C back into Z.
- Serves as the area-minimal adder stage for the datapath, with a start/busy/done handshake to the controller.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range ≥1.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      synchronous active-low reset, sampled on rising edge of clk
- start  input   1      request to begin an addition; sampled only when busy==0
- a      input   WIDTH  operand A; captured on the accepted start edge
- b      input   WIDTH  operand B; captured on the accepted start edge
- cin    input   1      carry-in; captured on the accepted start edge
- busy   output  1      high while an addition is in progress (state RUN)
- done   output  1      one-cycle pulse: sum/cout just updated
- sum    output  WIDTH  registered result; holds the last completed sum
- cout   output  1      registered carry-out of the last completed addition

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - state←IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry and bit counter cleared.
  - Reset has priority over everything, including mid-RUN: the operation is abandoned and no done pulse is produced.
- States: IDLE, RUN, DONE. busy==1 iff state==RUN. done==1 iff state==DONE.
- IDLE:
  - start==1 → load opA←a, opB←b, carry←cin, cnt←0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (one bit per edge, LSB first):
  - FA inputs: X=opA[0], Y=opB[0], Z=carry.
  - Each edge:
    - opA, opB shift right by 1 (zero fill).
    - Partial-sum register shifts right with FA.S inserted at bit WIDTH-1.
    - carry←FA.C.
    - cnt←cnt+1.
  - cnt width = clog2(WIDTH+1). On the edge where cnt==WIDTH-1 (last bit):
    - sum←{FA.S, partial[WIDTH-1:1]} (full result).
    - cout←FA.C.
    - state→DONE.
  - start is ignored while in RUN. Inputs a/b/cin may change freely after the load edge without effect.
- DONE (one cycle, done=1):
  - start==1 → reload exactly as from IDLE and go to RUN (back-to-back operation; done is still high for this cycle).
  - Otherwise → IDLE.
- Latency and outputs:
  - Start accepted at edge T0 → done high in the cycle following edge T0+WIDTH.
  - Throughput: one addition per WIDTH+1 cycles.
  - sum/cout change only on the final RUN edge; they hold their value through IDLE, DONE and the next RUN until that run's final edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- WIDTH==1: RUN lasts exactly one edge (cnt==0 is the last bit).
- X/Z on a, b or cin is only relevant at the load edge.

Test Plan:
- rst_n=0 for 2 edges, then release → busy=0, done=0, sum=0x00, cout=0; no activity without start.
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse at T0:
  - busy=1 for 8 cycles;
  - done=1 exactly after edge T0+8;
  - sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start re-asserted at T0+3 with different operands (mid-RUN) → ignored; result is that of the first operands; done pulses once.
- rst_n=0 at T0+4 of a run → next cycle busy=0, sum/cout=0, no done pulse. A fresh start afterwards computes correctly.
- start held high through DONE → second addition begins with no IDLE cycle: busy low only in the DONE cycle, done pulses once per result.
- Random regression of 1000 operand sets vs. a+b+cin, for both WIDTH=8 and WIDTH=1.
